// File: rtl/alu_pkg.sv
// alu_mc shared types: opcodes, flag indices, FSM states.
// ALU_MUL_EN enables the MUL opcode in alu_mc.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_SUM = 4'b0000,
    ALU_DIF = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_ORR = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SLR = 4'b0110,
    ALU_SAR = 4'b0111,
    ALU_MUL = 4'b1000
  } alu_op;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_mc_state;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc request/response bus.
// Request side valid/ready, response side valid/ready.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, op1, op2, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, op1, op2, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one-bit shifter and (ALU_MUL_EN)
// shift-add multiplier sharing one shift register.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] WMAX = WIDTH'(WIDTH);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic [WIDTH-1:0] amt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_load;
  logic [3:0]       md;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   psum;
`endif

  assign amt = (b > WMAX) ? WMAX : b;

  // Iteration count: saturated shift amount, or WIDTH steps for MUL
  always_comb begin
    cnt_load = amt[CW-1:0];
`ifdef ALU_MUL_EN
    if (mode == ALU_MUL) cnt_load = CMAX;
`endif
  end

  // One iteration step of the current mode
  always_comb begin
    sh_nxt = sh;
    carry  = 1'b0;
`ifdef ALU_MUL_EN
    acc_nxt = acc;
    psum    = '0;
`endif
    case (md)
      ALU_SLL: begin
        sh_nxt = {sh[WIDTH-2:0], 1'b0};
        carry  = sh[WIDTH-1];
      end
      ALU_SLR: begin
        sh_nxt = {1'b0, sh[WIDTH-1:1]};
        carry  = sh[0];
      end
      ALU_SAR: begin
        sh_nxt = {sh[WIDTH-1], sh[WIDTH-1:1]};
        carry  = sh[0];
      end
`ifdef ALU_MUL_EN
      ALU_MUL: begin
        psum    = {1'b0, acc} + {1'b0, sh[0] ? mcand : '0};
        acc_nxt = psum[WIDTH:1];
        sh_nxt  = {psum[0], sh[WIDTH-1:1]};
        carry   = |acc_nxt;
      end
`endif
      default: ;
    endcase
  end

  assign done   = (cnt == CW'(1));
  assign result = sh_nxt;

  // Load on start, then step until the counter drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
      md  <= '0;
`ifdef ALU_MUL_EN
      acc   <= '0;
      mcand <= '0;
`endif
    end else if (start) begin
      sh  <= a;
      cnt <= cnt_load;
      md  <= mode;
`ifdef ALU_MUL_EN
      acc   <= '0;
      mcand <= b;
`endif
    end else if (cnt != '0) begin
      sh  <= sh_nxt;
      cnt <= cnt - CW'(1);
`ifdef ALU_MUL_EN
      acc <= acc_nxt;
`endif
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides.
// Define ALU_MUL_EN to build the iterative multiplier.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  alu_mc_if.slave  bus
);
  alu_mc_state      state_q;
  alu_mc_state      state_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       flags_q;
  logic [3:0]       flags_d;
  logic             cap;
  logic             start;
  logic             need_iter;
  logic [WIDTH-1:0] res1;
  logic             c1;
  logic             v1;
  logic [WIDTH:0]   sum;
  logic             it_done;
  logic [WIDTH-1:0] it_res;
  logic             it_c;

  function automatic logic [3:0] mk_flags(
    input logic [WIDTH-1:0] r,
    input logic             c,
    input logic             v
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign sum = {1'b0, bus.op1}
             + {1'b0, bus.op[0] ? ~bus.op2 : bus.op2}
             + {{WIDTH{1'b0}}, bus.op[0]};

  // Single-cycle datapath and iterative-path selection
  always_comb begin
    res1      = '0;
    c1        = 1'b0;
    v1        = 1'b0;
    need_iter = 1'b0;
    case (bus.op)
      ALU_SUM, ALU_DIF: begin
        res1 = sum[WIDTH-1:0];
        c1   = sum[WIDTH];
        v1   = ~(bus.op[0] ^ bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1])
             & (bus.op1[WIDTH-1] ^ sum[WIDTH-1]);
      end
      ALU_AND: res1 = bus.op1 & bus.op2;
      ALU_ORR: res1 = bus.op1 | bus.op2;
      ALU_XOR: res1 = bus.op1 ^ bus.op2;
      ALU_SLL, ALU_SLR, ALU_SAR: begin
        res1      = bus.op1;
        need_iter = (bus.op2 != '0);
      end
`ifdef ALU_MUL_EN
      ALU_MUL: need_iter = 1'b1;
`endif
      default: ;
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (bus.op),
    .a      (bus.op1),
    .b      (bus.op2),
    .done   (it_done),
    .result (it_res),
    .carry  (it_c)
  );

  // Next state, iteration start and result capture
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    cap      = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (need_iter) begin
            start   = 1'b1;
            state_d = ST_BUSY;
          end else begin
            cap      = 1'b1;
            result_d = res1;
            flags_d  = mk_flags(res1, c1, v1);
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (it_done) begin
          cap      = 1'b1;
          result_d = it_res;
          flags_d  = mk_flags(it_res, it_c, 1'b0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Result and flags hold until the next completed operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (cap) begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the single-cycle core ALU, with a valid/ready handshake on both sides.
- Logic, add and subtract complete in one cycle.
- Shifts use an iterative one-bit-per-cycle shifter instead of a barrel shifter, and the arithmetic right shift is now implemented.
- An optional iterative shift-add multiplier is available.
- Sits in the execute stage: the pipeline holds the instruction while `in_ready` is low or `out_valid` is unconsumed.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 4 and a power of two.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request; high only in IDLE.
- `op` in 4: `alu_op` opcode from `alu_pkg`.
- `op1`, `op2` in WIDTH each: operands, two's complement.
- `out_valid` out 1: result and flags are valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out WIDTH: registered result.
- `flags` out 4: {N, Z, C, V}, registered.

## Operation
- Opcodes:
  - 0000 SUM
  - 0001 DIF
  - 0010 AND
  - 0011 ORR
  - 0100 XOR
  - 0101 SLL
  - 0110 SLR
  - 0111 SAR
  - 1000 MUL
  - all others illegal.
- States: IDLE, BUSY, DONE.
  - IDLE: when `in_valid` is high, capture `op`, `op1`, `op2`.
    - Single-cycle ops go to DONE.
    - Shifts with amount 0 go to DONE.
    - Otherwise go to BUSY.
  - BUSY: iterate until the down-counter reaches 0, then go to DONE.
  - DONE: `out_valid` is high; when `out_ready` is high, go to IDLE.
- SUM/DIF: sum = op1 + (op[0] ? ~op2 : op2) + op[0], computed at WIDTH+1 bits.
  - C = bit WIDTH of the sum; for DIF, C=1 means no borrow.
  - V = ~(op[0]^op1[MSB]^op2[MSB]) & (op1[MSB]^result[MSB]).
- Logic ops: C=0, V=0.
- Shifts:
  - Amount = op2 as unsigned, saturated to WIDTH.
  - One bit position per BUSY cycle.
  - SLR fills with 0; SAR fills with op1[MSB].
  - C = last bit shifted out, or 0 when the amount is 0. V=0.
- Illegal opcodes (and MUL when compiled out): result 0, flags {0,1,0,0}, one-cycle latency.
- N = result[WIDTH-1] and Z = (result == 0) for every op.
- Result and flags are stable in DONE until the handshake completes.
- No new request is accepted in BUSY or DONE.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE
  - `in_ready` 1
  - `out_valid` 0
  - `result` 0
  - `flags` 0
  - counter 0
  - any in-flight operation is discarded.
- Latency, counted from the accepting edge to the edge after which `out_valid` is high:
  - logic, add/sub, illegal, shift amount 0: 1 cycle.
  - shift by n: 1+n cycles, with n ≤ WIDTH.
  - MUL: 1+WIDTH cycles.
- `in_ready` falls on the edge after acceptance.
- `out_valid` falls, and `in_ready` rises, on the edge where `out_valid` and `out_ready` are both high.
- Back-to-back throughput: one op per 2 cycles minimum; no same-cycle bypass from DONE to accept.
- `out_ready` is ignored outside DONE.
- `in_valid` is ignored outside IDLE.

## Configuration
- `ALU_MUL_EN` defined:
  - MUL is implemented as a WIDTH-cycle shift-add multiplier using the shared iterative datapath.
  - result = low WIDTH bits of the unsigned product.
  - C = 1 if any upper product bit is nonzero.
  - V = 0.
- `ALU_MUL_EN` undefined: MUL decodes as illegal and no multiplier logic is synthesised.

## Structure
- `alu_pkg` contains:
  - `alu_op` enum, 4-bit.
  - flag index localparams `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
  - state enum `alu_mc_state`.
- One sub-module, `alu_iter_unit`: holds the shift register, the counter and (under `ALU_MUL_EN`) the accumulator.
  - Inputs: start, mode, operands.
  - Outputs: done, result, carry.
- The FSM, single-cycle datapath and flag logic stay in `alu_mc`.

## Test plan
All cases use WIDTH=32.
- SUM 0x7FFFFFFF+0x00000001 -> result 0x80000000, flags N=1 Z=0 C=0 V=1, `out_valid` one cycle after accept.
- DIF 5-7 -> result 0xFFFFFFFE, N=1 C=0 V=0; DIF 7-7 -> result 0, Z=1 C=1.
- SAR 0x80000000 by 4 -> result 0xF8000000, N=1 C=0, latency 5.
  - SLR of the same operand -> result 0x08000000, N=0.
- SLL 0x00000001 by op2=40 (saturated to 32) -> result 0, Z=1 C=1, latency 33.
  - SLL by 0 -> result unchanged, C=0, latency 1.
- MUL 0x00010000 × 0x00010000 with `ALU_MUL_EN` -> result 0, Z=1 C=1, latency 33.
  - Without `ALU_MUL_EN` -> result 0, flags 0100, latency 1.
- Handshake and reset:
  - Hold `out_ready` low 3 cycles in DONE -> result/flags stable, `in_ready`=0, a second `in_valid` is not accepted.
  - Assert `rst` mid-shift -> `out_valid`=0, `in_ready`=1, `result`=0 immediately; no stale result afterwards.
